// File: rtl/surf4_i2c_arbiter.sv
// -----------------------------------------------------------------------------
// surf4_i2c_arbiter
//
// Round-robin arbiter that shares the single 8-bit WISHBONE port of the I2C
// core between NUM_MASTERS requesters. It replaces the fixed grant-bit mux.
// A master that holds its lock input keeps the grant across cyc gaps, so it
// can chain several START..STOP sequences without being pre-empted.
//
// Ownership FSM: IDLE -> OWNED <-> LOCKED -> IDLE. Every change of owner
// passes through one IDLE cycle, so the core always sees cyc low for at least
// one cycle between different owners, and the grant never moves while
// i2c_cyc_o is high.
//
// Optional feature (macro SURF4_I2C_ARB_TIMEOUT_EN):
//   An ownership watchdog. A 16-bit counter clears on every grant change and
//   on every core ack, and counts cycles spent in OWNED/LOCKED. When it
//   reaches TIMEOUT_CYCLES the arbiter drops to IDLE, pulses m_err_o for the
//   owner if its stb is high, and sets the sticky timeout_o. The timed-out
//   master must drop cyc before it can be granted again.
//   Without the macro the watchdog and timeout_o do not exist.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   m_cyc_i/stb_i/we_i    per-master WB control, one bit per master
//   m_adr_i               per-master 7-bit address, master k at [7k+6:7k]
//   m_dat_i               per-master write data,  master k at [8k+7:8k]
//   m_lock_i              per-master bus lock
//   m_ack_o/err_o/rty_o   per-master termination, routed to the owner only
//   m_dat_o               read data, broadcast to all masters
//   gnt_o                 one-hot current owner, zero when idle
//   i2c_*                 WB master port towards the I2C core (sel tied 0)
//   timeout_o             sticky watchdog flag (macro builds only)
// -----------------------------------------------------------------------------
module surf4_i2c_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_MASTERS-1:0]     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]     m_stb_i,
    input  logic [NUM_MASTERS-1:0]     m_we_i,
    input  logic [7*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [8*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [NUM_MASTERS-1:0]     m_lock_i,
    output logic [NUM_MASTERS-1:0]     m_ack_o,
    output logic [NUM_MASTERS-1:0]     m_err_o,
    output logic [NUM_MASTERS-1:0]     m_rty_o,
    output logic [7:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]     gnt_o,
    output logic                       i2c_cyc_o,
    output logic                       i2c_stb_o,
    output logic                       i2c_we_o,
    output logic [6:0]                 i2c_adr_o,
    output logic [7:0]                 i2c_dat_o,
    output logic                       i2c_sel_o,
    input  logic [7:0]                 i2c_dat_i,
    input  logic                       i2c_ack_i,
    input  logic                       i2c_err_i,
    input  logic                       i2c_rty_i
`ifdef SURF4_I2C_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_o
`endif
);

    // Elaboration-time guard: an illegal configuration instantiates a module
    // that does not exist, so the build stops instead of producing bad logic.
    localparam bit CFG_OK = (NUM_MASTERS >= 2) && (NUM_MASTERS <= 4) &&
                            (TIMEOUT_CYCLES >= 16) && (TIMEOUT_CYCLES <= 65535);
    generate
        if (!CFG_OK) begin : g_bad_cfg
            surf4_i2c_arbiter_illegal_configuration u_bad_cfg ();
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [NUM_MASTERS-1:0] owner_reg, owner_next;   // one-hot, zero in IDLE
    logic [NUM_MASTERS-1:0] ptr_reg, ptr_next;       // one-hot priority pointer
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] win_oh;

    logic [NUM_MASTERS-1:0] own_cyc_v, own_stb_v, own_we_v, own_lock_v;
    logic [6:0]             own_adr_v [NUM_MASTERS];
    logic [7:0]             own_dat_v [NUM_MASTERS];
    logic                   owner_cyc, owner_stb, owner_we, owner_lock;
    logic [6:0]             owner_adr;
    logic [7:0]             owner_dat;
    logic                   owned;

    logic                   to_hit;                  // watchdog expires this cycle
    logic [NUM_MASTERS-1:0] to_err;                  // watchdog err pulse

    // ---------------------------------------------------------------------
    // Owner select: mask every master's signals with its grant bit, then
    // OR-reduce. owner_reg is one-hot, so at most one term is non-zero.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
            assign own_cyc_v[gi]  = owner_reg[gi] & m_cyc_i[gi];
            assign own_stb_v[gi]  = owner_reg[gi] & m_stb_i[gi];
            assign own_we_v[gi]   = owner_reg[gi] & m_we_i[gi];
            assign own_lock_v[gi] = owner_reg[gi] & m_lock_i[gi];
            assign own_adr_v[gi]  = owner_reg[gi] ? m_adr_i[7*gi +: 7] : 7'd0;
            assign own_dat_v[gi]  = owner_reg[gi] ? m_dat_i[8*gi +: 8] : 8'd0;
        end
    endgenerate

    assign owner_cyc  = |own_cyc_v;
    assign owner_stb  = |own_stb_v;
    assign owner_we   = |own_we_v;
    assign owner_lock = |own_lock_v;

    always_comb begin
        owner_adr = 7'd0;
        owner_dat = 8'd0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            owner_adr = owner_adr | own_adr_v[k];
            owner_dat = owner_dat | own_dat_v[k];
        end
    end

    // ---------------------------------------------------------------------
    // Round-robin winner: first eligible requester at or after the pointer.
    // Offsets are scanned from the farthest to the nearest so the nearest
    // hit overwrites the others.
    // ---------------------------------------------------------------------
    always_comb begin
        win_oh = '0;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (ptr_reg[k] && eligible[(k + off) % NUM_MASTERS]) begin
                    win_oh = '0;
                    win_oh[(k + off) % NUM_MASTERS] = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Ownership FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            ptr_reg   <= NUM_MASTERS'(1);    // master 0 has top priority
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|win_oh) begin
                    state_next = ST_OWNED;
                    owner_next = win_oh;
                    // Pointer moves to the master just after the winner.
                    ptr_next   = {win_oh[NUM_MASTERS-2:0], win_oh[NUM_MASTERS-1]};
                end
            end
            ST_OWNED: begin
                if (!owner_cyc) begin
                    if (owner_lock) begin
                        state_next = ST_LOCKED;
                    end else begin
                        state_next = ST_IDLE;
                        owner_next = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (owner_cyc) begin
                    state_next = ST_OWNED;
                end else if (!owner_lock) begin
                    state_next = ST_IDLE;
                    owner_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                owner_next = '0;
            end
        endcase
        if (to_hit) begin
            state_next = ST_IDLE;
            owner_next = '0;
        end
    end

`ifdef SURF4_I2C_ARB_TIMEOUT_EN
    // ---------------------------------------------------------------------
    // Ownership watchdog
    // ---------------------------------------------------------------------
    logic [15:0]            cnt_reg, cnt_next;
    logic                   timeout_reg;
    logic [NUM_MASTERS-1:0] blocked_reg, blocked_next;

    // cnt_reg holds the number of ownership cycles already completed, so it
    // equals TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th owned cycle.
    assign to_hit   = (state_reg != ST_IDLE) && (cnt_reg == 16'(TIMEOUT_CYCLES - 1));
    assign to_err   = (to_hit && owner_stb) ? owner_reg : '0;
    assign eligible = m_cyc_i & ~blocked_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if ((owner_next != owner_reg) || i2c_ack_i) begin
            cnt_next = 16'd0;
        end else if (state_reg != ST_IDLE) begin
            cnt_next = cnt_reg + 16'd1;
        end
        // A timed-out master stays blocked until it lowers cyc.
        blocked_next = (blocked_reg | (to_hit ? owner_reg : '0)) & m_cyc_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg     <= 16'd0;
            timeout_reg <= 1'b0;
            blocked_reg <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_reg | to_hit;
            blocked_reg <= blocked_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign to_hit   = 1'b0;
    assign to_err   = '0;
    assign eligible = m_cyc_i;
`endif

    // ---------------------------------------------------------------------
    // Datapath to the core and back to the masters. IDLE and LOCKED present
    // an idle bus; reset forces IDLE asynchronously, so everything reads 0.
    // ---------------------------------------------------------------------
    assign owned     = (state_reg == ST_OWNED);
    assign gnt_o     = owner_reg;
    assign i2c_cyc_o = owned & owner_cyc;
    assign i2c_stb_o = owned & owner_stb;
    assign i2c_we_o  = owned & owner_we;
    assign i2c_adr_o = owned ? owner_adr : 7'd0;
    assign i2c_dat_o = owned ? owner_dat : 8'd0;
    assign i2c_sel_o = 1'b0;

    assign m_dat_o = i2c_dat_i;
    assign m_ack_o = (owned && i2c_ack_i) ? owner_reg : '0;
    assign m_err_o = ((owned && i2c_err_i) ? owner_reg : '0) | to_err;
    assign m_rty_o = (owned && i2c_rty_i) ? owner_reg : '0;

endmodule
